// File: rtl/memctl_pkg.sv
// memctl_pkg: shared types and widths for the SRAM access arbiter.
package memctl_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {OWN_CPU, OWN_VID} owner_t;
endpackage

// File: rtl/sram_access_arbiter_reg.sv
// sram_access_arbiter_reg: loadable data register with synchronous clear.
module sram_access_arbiter_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (load) q <= d;
endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one SRAM between the CPU port and the video fetch port,
// holding the latched access for WAIT_STATES+1 cycles and pulsing completion once.
module sram_access_arbiter
   import memctl_pkg::*;
#(
   parameter int WAIT_STATES    = 1,
   parameter int VID_MAX_STREAK = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              CPU_Req,
   input  logic              CPU_R_W,
   input  logic [ADDR_W-1:0] CPU_Addr,
   input  logic [DATA_W-1:0] CPU_WData,
   output logic [DATA_W-1:0] CPU_RData,
   output logic              CPU_Ready,
   input  logic              Vid_Req,
   input  logic [ADDR_W-1:0] Vid_Addr,
   output logic [DATA_W-1:0] Vid_RData,
   output logic              Vid_Valid,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_DOut,
   input  logic [DATA_W-1:0] Mem_DIn,
   output logic              Mem_CE,
   output logic              Mem_OE,
   output logic              Mem_WE
);
   localparam logic [3:0] MAX_STREAK = 4'(VID_MAX_STREAK);
   state_t            state, state_nx;
   owner_t            owner;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        cnt;
   logic [3:0]        streak;
   logic              cpu_win, grant, capture;
   // Video is favoured unless the CPU has been starved for MAX_STREAK grants.
   assign cpu_win = CPU_Req && (!Vid_Req || streak == MAX_STREAK);
   assign grant   = state == IDLE && (CPU_Req || Vid_Req);
   assign capture = state == ACCESS && cnt == 3'd0 && !rw_q;
   always_ff @(posedge Clk)
      if (Reset) begin
         state   <= IDLE;
         owner   <= OWN_CPU;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt     <= 3'd0;
         streak  <= 4'd0;
      end else begin
         state <= state_nx;
         if (grant) begin
            owner   <= cpu_win ? OWN_CPU : OWN_VID;
            rw_q    <= cpu_win && CPU_R_W;
            addr_q  <= cpu_win ? CPU_Addr : Vid_Addr;
            wdata_q <= cpu_win ? CPU_WData : wdata_q;
            cnt     <= 3'(WAIT_STATES);
         end else if (state == ACCESS && cnt != 3'd0)
            cnt <= cnt - 3'd1;
         if (state == IDLE)
            streak <= (cpu_win || !CPU_Req) ? 4'd0 :
                      (Vid_Req && streak < MAX_STREAK) ? streak + 4'd1 : streak;
      end
   always_comb begin
      state_nx = state == IDLE   ? (grant ? ACCESS : IDLE) :
                 state == ACCESS ? (cnt == 3'd0 ? DONE : ACCESS) : IDLE;
   end
   always_comb begin
      Mem_CE    = state == ACCESS;
      Mem_OE    = Mem_CE && !rw_q;
      Mem_WE    = Mem_CE && rw_q;
      CPU_Ready = state == DONE && owner == OWN_CPU;
      Vid_Valid = state == DONE && owner == OWN_VID;
   end
   assign Mem_Addr = addr_q;
   assign Mem_DOut = wdata_q;
   sram_access_arbiter_reg #(.W(DATA_W)) u_cpu_rdata (
      .clk (Clk),
      .rst (Reset),
      .load(capture && owner == OWN_CPU),
      .d   (Mem_DIn),
      .q   (CPU_RData)
   );
   sram_access_arbiter_reg #(.W(DATA_W)) u_vid_rdata (
      .clk (Clk),
      .rst (Reset),
      .load(capture && owner == OWN_VID),
      .d   (Mem_DIn),
      .q   (Vid_RData)
   );
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed and random traffic against a transaction-level model.
module tb_sram_access_arbiter;
   localparam int W = 1;
   localparam int M = 2;
   logic        Clk = 1'b0, Reset = 1'b1;
   logic        CPU_Req = 1'b0, CPU_R_W = 1'b0;
   logic [15:0] CPU_Addr = '0, CPU_WData = '0, CPU_RData;
   logic        CPU_Ready;
   logic        Vid_Req = 1'b0;
   logic [15:0] Vid_Addr = '0, Vid_RData;
   logic        Vid_Valid;
   logic [15:0] Mem_Addr, Mem_DOut, Mem_DIn;
   logic        Mem_CE, Mem_OE, Mem_WE;
   logic [15:0] sram [256];
   logic        seed_en = 1'b0;
   logic [7:0]  seed_a = '0;
   logic [15:0] seed_d = '0;
   always #5 Clk = ~Clk;
   assign Mem_DIn = sram[Mem_Addr[7:0]];
   always @(posedge Clk) begin
      if (seed_en) sram[seed_a] <= seed_d;
      if (Mem_CE && Mem_WE) sram[Mem_Addr[7:0]] <= Mem_DOut;
   end
   sram_access_arbiter #(.WAIT_STATES(W), .VID_MAX_STREAK(M)) dut (
      .Clk(Clk), .Reset(Reset),
      .CPU_Req(CPU_Req), .CPU_R_W(CPU_R_W), .CPU_Addr(CPU_Addr), .CPU_WData(CPU_WData),
      .CPU_RData(CPU_RData), .CPU_Ready(CPU_Ready),
      .Vid_Req(Vid_Req), .Vid_Addr(Vid_Addr), .Vid_RData(Vid_RData), .Vid_Valid(Vid_Valid),
      .Mem_Addr(Mem_Addr), .Mem_DOut(Mem_DOut), .Mem_DIn(Mem_DIn),
      .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
   );
   int errors = 0, checks = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Transaction-level model: a grant at edge g owns the SRAM for edges g..g+W+1.
   logic [15:0] ref_mem [256];
   int          e = 0, m_g = 0, m_streak = 0;
   bit          m_act = 0, m_own = 0, m_rw = 0, rst_edge = 0;
   logic [15:0] m_addr = '0, m_wd = '0, exp_cpu_rd = '0, exp_vid_rd = '0;
   int          cpu_cnt = 0, vid_cnt = 0, ord[$];
   bit          rnd = 0, cpu_hold = 0, vid_hold = 0;
   task automatic model_edge();
      int  d;
      bit  cw;
      d = e - m_g;
      e++;
      rst_edge = Reset;
      if (Reset) begin
         m_act = 0;
         m_streak = 0;
         exp_cpu_rd = '0;
         exp_vid_rd = '0;
      end else if (m_act && d <= W + 1) begin
         if (d <= W && m_rw) ref_mem[m_addr[7:0]] = m_wd;
         if (d == W && !m_rw) begin
            if (m_own) exp_vid_rd = ref_mem[m_addr[7:0]];
            else       exp_cpu_rd = ref_mem[m_addr[7:0]];
         end
      end else begin
         cw = CPU_Req && (!Vid_Req || m_streak == M);
         if (CPU_Req || Vid_Req) begin
            m_act  = 1;
            m_g    = e;
            m_own  = !cw;
            m_rw   = cw && CPU_R_W;
            m_addr = cw ? CPU_Addr : Vid_Addr;
            m_wd   = CPU_WData;
         end
         if (cw || !CPU_Req) m_streak = 0;
         else if (Vid_Req && m_streak < M) m_streak++;
      end
   endtask
   function automatic bit busy(input bit own);
      return m_act && m_own == own && (e - m_g) <= W + 1;
   endfunction
   task automatic new_cpu();
      CPU_R_W   = 1'($urandom);
      CPU_Addr  = 16'($urandom);
      CPU_WData = 16'($urandom);
   endtask
   task automatic cycle();
      int d;
      bit acc, dn;
      model_edge();
      @(posedge Clk);
      #1;
      d   = e - m_g;
      acc = m_act && d >= 0 && d <= W;
      dn  = m_act && d == W + 1;
      check("ce", Mem_CE, acc);
      check("oe", Mem_OE, acc && !m_rw);
      check("we", Mem_WE, acc && m_rw);
      check("cpu_ready", CPU_Ready, dn && !m_own);
      check("vid_valid", Vid_Valid, dn && m_own);
      check("cpu_rdata", CPU_RData, exp_cpu_rd);
      check("vid_rdata", Vid_RData, exp_vid_rd);
      if (acc) check("mem_addr", Mem_Addr, m_addr);
      if (acc && m_rw) check("mem_dout", Mem_DOut, m_wd);
      if (rst_edge) begin
         check("rst_addr", Mem_Addr, 0);
         check("rst_dout", Mem_DOut, 0);
      end
      if (CPU_Ready) begin
         cpu_cnt++;
         ord.push_back(0);
         CPU_Req = cpu_hold;
         if (cpu_hold) new_cpu();
      end
      if (Vid_Valid) begin
         vid_cnt++;
         ord.push_back(1);
         Vid_Req = vid_hold;
         if (vid_hold) Vid_Addr = 16'($urandom);
      end
      if (rnd) begin
         Reset = $urandom_range(199) == 0;
         if (busy(0)) begin
            new_cpu();
            if ($urandom_range(15) == 0) CPU_Req = 1'b0;
         end else if (!CPU_Req && $urandom_range(3) == 0) begin
            new_cpu();
            CPU_Req = 1'b1;
         end
         if (busy(1)) begin
            Vid_Addr = 16'($urandom);
            if ($urandom_range(15) == 0) Vid_Req = 1'b0;
         end else if (!Vid_Req && $urandom_range(2) == 0) begin
            Vid_Addr = 16'($urandom);
            Vid_Req = 1'b1;
         end
      end
   endtask
   int n0;
   int pat [6] = '{1, 1, 0, 1, 1, 0};
   initial begin
      seed_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         seed_a = 8'(i);
         seed_d = (i == 0) ? 16'h1234 : 16'($urandom);
         ref_mem[i] = seed_d;
         cycle();
      end
      seed_en = 1'b0;
      Reset = 1'b0;
      cycle();
      // CPU read
      n0 = cpu_cnt;
      CPU_Addr = 16'h3000; CPU_R_W = 1'b0; CPU_Req = 1'b1;
      repeat (6) cycle();
      check("read_pulses", cpu_cnt - n0, 1);
      check("read_data", CPU_RData, 16'h1234);
      // CPU write
      n0 = cpu_cnt;
      CPU_Addr = 16'h3001; CPU_WData = 16'hBEEF; CPU_R_W = 1'b1; CPU_Req = 1'b1;
      repeat (6) cycle();
      check("write_pulses", cpu_cnt - n0, 1);
      check("write_sram", sram[1], 16'hBEEF);
      // simultaneous requests
      ord.delete();
      CPU_Addr = 16'h3002; CPU_R_W = 1'b0; CPU_Req = 1'b1;
      Vid_Addr = 16'h4000; Vid_Req = 1'b1;
      repeat (12) cycle();
      check("tie_pulses", ord.size(), 2);
      check("tie_first", ord.size() > 0 ? ord[0] : 9, 1);
      check("tie_second", ord.size() > 1 ? ord[1] : 9, 0);
      // sustained contention
      ord.delete();
      cpu_hold = 1; vid_hold = 1;
      new_cpu(); CPU_Req = 1'b1;
      Vid_Addr = 16'h4100; Vid_Req = 1'b1;
      for (int i = 0; i < 60 && ord.size() < 6; i++) cycle();
      cpu_hold = 0; vid_hold = 0;
      for (int i = 0; i < 6; i++) check($sformatf("streak_order%0d", i), ord.size() > i ? ord[i] : 9, pat[i]);
      repeat (20) cycle();
      // reset in the second ACCESS cycle with the request held
      n0 = cpu_cnt;
      CPU_Addr = 16'h3010; CPU_R_W = 1'b0; CPU_Req = 1'b1;
      cycle();
      cycle();
      Reset = 1'b1;
      cycle();
      check("rst_mid_ce", Mem_CE, 0);
      check("rst_mid_ready", cpu_cnt - n0, 0);
      Reset = 1'b0;
      repeat (6) cycle();
      check("rst_regrant", cpu_cnt - n0, 1);
      // request dropped during ACCESS
      n0 = cpu_cnt;
      CPU_Addr = 16'h3020; CPU_R_W = 1'b0; CPU_Req = 1'b1;
      cycle();
      CPU_Req = 1'b0;
      repeat (6) cycle();
      check("drop_pulses", cpu_cnt - n0, 1);
      // random traffic
      rnd = 1;
      repeat (3000) cycle();
      rnd = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
